// File: rtl/lstm_acc_pkg.sv
// Shared types and sizing helpers for the temp_buff read-side feeder.
package lstm_acc_pkg;

  localparam int unsigned DEF_FEATURE_BITS = 4;
  localparam int unsigned DEF_M            = 9;
  localparam int unsigned DEF_DATA_W       = 16;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_ADDR_W       = 2 * DEF_FEATURE_BITS;
  localparam int unsigned DEF_BEATS        = DEF_M * DEF_M;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  // Store / generator address width for a given feature-count width.
  function automatic int unsigned addr_w(input int unsigned feature_bits);
    return 2 * feature_bits;
  endfunction

  // Beats per job (and store depth) for a given feature count.
  function automatic int unsigned beats(input int unsigned m);
    return m * m;
  endfunction

endpackage

// File: rtl/temp_buff_feeder_if.sv
// Address-generator link and systolic-array output link of the feeder.
interface temp_buff_feeder_if #(
  parameter int unsigned ADDR_W = lstm_acc_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = lstm_acc_pkg::DEF_DATA_W
) ();

  logic              ag_start;
  logic [ADDR_W-1:0] ag_address;
  logic              ag_done;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Feeder side
  modport master (
    output ag_start, out_valid, out_data, out_last,
    input  ag_address, ag_done, out_ready
  );

  // Address generator / systolic array side
  modport slave (
    input  ag_start, out_valid, out_data, out_last,
    output ag_address, ag_done, out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage, contents not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/temp_buff_feeder.sv
// Read-side sequencer for temp_buff: operand store, address-generator credit
// control and a skid FIFO towards the systolic array row input.
module temp_buff_feeder
  import lstm_acc_pkg::*;
#(
  parameter int unsigned FEATURE_BITS = DEF_FEATURE_BITS,
  parameter int unsigned M            = DEF_M,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [2*FEATURE_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      go,
  temp_buff_feeder_if.master        link,
  output logic                      busy,
  output logic                      done,
  output logic                      addr_err
);

  localparam int unsigned ADDR_W = addr_w(FEATURE_BITS);
  localparam int unsigned BEATS  = beats(M);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned IDX_W  = $clog2(BEATS);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FIFO_W = DATA_W + 1;

  feeder_state_t     state;
  feeder_state_t     state_next;
  logic [CNT_W-1:0]  issued_cnt;
  logic              issue;
  logic              credit_ok;
  logic              rd_in_range;
  logic              wr_in_range;
  logic              rd_valid;
  logic              rd_last;
  logic [DATA_W-1:0] rd_data;
  logic [FIFO_W-1:0] fifo_head;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              start_job;

  logic [DATA_W-1:0] store [BEATS];

  assign rd_in_range = (CNT_W'(link.ag_address) < CNT_W'(BEATS));
  assign wr_in_range = (CNT_W'(wr_addr) < CNT_W'(BEATS));
  // Pops never grant credit in the same cycle, so out_ready has no path to ag_start.
  assign credit_ok   = ((FCNT_W+1)'(fifo_cnt) + (FCNT_W+1)'(rd_valid)) < (FCNT_W+1)'(FIFO_DEPTH);
  assign issue       = link.ag_start && !link.ag_done;
  assign start_job   = (state == IDLE) && go;

  // State register
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_next    = state;
    link.ag_start = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_next = RUN;
      end
      RUN: begin
        busy          = 1'b1;
        link.ag_start = (issued_cnt != CNT_W'(BEATS)) && credit_ok;
        if (issued_cnt == CNT_W'(BEATS)) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && fifo_head[DATA_W]) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Issue counter and sticky out-of-range flag, both cleared by an accepted go
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      issued_cnt <= '0;
      addr_err   <= 1'b0;
    end else if (start_job) begin
      issued_cnt <= '0;
      addr_err   <= 1'b0;
    end else if (issue) begin
      if (issued_cnt != CNT_W'(BEATS)) issued_cnt <= issued_cnt + CNT_W'(1);
      if (!rd_in_range) addr_err <= 1'b1;
    end
  end

  // Store write port; out-of-range writes dropped, contents not reset
  always_ff @(posedge sys_clk) begin
    if (wr_en && wr_in_range) store[IDX_W'(wr_addr)] <= wr_data;
  end

  // Registered read; a same-cycle write to the same entry returns the old word
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_data <= rd_in_range ? store[IDX_W'(link.ag_address)] : '0;
        rd_last <= (issued_cnt == CNT_W'(BEATS - 1));
      end
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (reset),
    .push      (rd_valid),
    .push_data ({rd_last, rd_data}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign pop            = link.out_valid && link.out_ready;
  assign link.out_valid = !fifo_empty;
  assign link.out_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign link.out_last  = !fifo_empty && fifo_head[DATA_W];

  // Credit rule guarantees an inflight read always finds room
  a_no_overflow: assert property (@(posedge sys_clk) disable iff (reset) !(rd_valid && fifo_full));

endmodule

// File: tb/tb_temp_buff_feeder.sv
// Scoreboard bench for temp_buff_feeder with a behavioural address generator.
module tb_temp_buff_feeder;

  localparam int unsigned BEATS = 81;

  logic        sys_clk;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        go;
  logic        busy;
  logic        done;
  logic        addr_err;

  temp_buff_feeder_if lk ();

  temp_buff_feeder dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .go       (go),
    .link     (lk),
    .busy     (busy),
    .done     (done),
    .addr_err (addr_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int job_id = 0;
  int issued_tb = 0;
  int pops = 0;
  int done_cnt = 0;

  logic [16:0] exp_q [$];
  logic [15:0] model [BEATS];
  logic [7:0]  seq [BEATS];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Address generator: walks seq[], advances once per accepted issue
  initial begin
    int ag_idx;
    int ag_job;
    logic fire;
    ag_idx = BEATS;
    ag_job = 0;
    lk.ag_address = 8'd0;
    lk.ag_done = 1'b1;
    forever begin
      @(negedge sys_clk);
      fire = lk.ag_start && !lk.ag_done && !reset;
      @(posedge sys_clk);
      #1;
      if (ag_job != job_id) begin
        ag_job = job_id;
        ag_idx = 0;
      end else if (fire) begin
        ag_idx++;
        issued_tb++;
      end
      lk.ag_done = (ag_idx >= BEATS);
      lk.ag_address = (ag_idx < BEATS) ? seq[ag_idx] : 8'd0;
    end
  end

  // Monitor: pops expected beats on every accepted output word
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge sys_clk);
      if (!reset) begin
        if (done) done_cnt++;
        if (lk.out_valid && lk.out_ready) begin
          pops++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat %0d: unexpected word last=%0b data=%h", pops, lk.out_last, lk.out_data);
          end else begin
            e = exp_q.pop_front();
            if ({lk.out_last, lk.out_data} !== e) begin
              n_err++;
              $display("FAIL beat %0d: got last=%0b data=%h, want last=%0b data=%h",
                       pops, lk.out_last, lk.out_data, e[16], e[15:0]);
            end
          end
        end
      end
    end
  end

  task automatic store_wr(input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge sys_clk);
    #1;
    wr_en = 1'b0;
    if (a < BEATS) model[a] = d;
  endtask

  task automatic seq_identity();
    for (int i = 0; i < BEATS; i++) seq[i] = 8'(i);
  endtask

  task automatic start_job();
    logic [7:0] a;
    logic [15:0] d;
    for (int i = 0; i < BEATS; i++) begin
      a = seq[i];
      d = (a < BEATS) ? model[a] : 16'h0000;
      exp_q.push_back({(i == BEATS - 1), d});
    end
    job_id++;
    @(posedge sys_clk);
    #1;
    go = 1'b1;
    @(posedge sys_clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input logic exp_err);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge sys_clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, " done seen"}, 32'(got), 32'd1);
    @(posedge sys_clk);
    #1;
    chk({name, " done pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({name, " queue drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, " addr_err"}, 32'(addr_err), 32'(exp_err));
  endtask

  task automatic wait_pops(input int p0, input int n);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge sys_clk);
      if (pops - p0 >= n) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait pops", 32'(got), 32'd1);
  endtask

  initial begin
    int d0;
    int p0;
    int i0;
    int lat;
    logic [15:0] hold;
    logic stable;
    logic got;

    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = 8'd0;
    wr_data = 16'd0;
    go = 1'b0;
    lk.out_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset out_valid", 32'(lk.out_valid), 32'd0);
    chk("reset ag_start", 32'(lk.ag_start), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset addr_err", 32'(addr_err), 32'd0);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;

    // Test 1: store[a]=a+100, streaming with out_ready high
    for (int a = 0; a < BEATS; a++) store_wr(8'(a), 16'(a + 100));
    lk.out_ready = 1'b1;
    seq_identity();
    d0 = done_cnt;
    start_job();
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      if (lk.out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge sys_clk);
      lat++;
    end
    chk("t1 first valid seen", 32'(got), 32'd1);
    chk("t1 go-to-valid latency", 32'(lat), 32'd3);
    chk("t1 busy", 32'(busy), 32'd1);
    wait_done("t1", d0, 1'b0);

    // Test 2: 20-cycle back-pressure mid-job
    seq_identity();
    d0 = done_cnt;
    p0 = pops;
    i0 = issued_tb;
    start_job();
    wait_pops(p0, 20);
    @(posedge sys_clk);
    #1;
    lk.out_ready = 1'b0;
    @(negedge sys_clk);
    hold = lk.out_data;
    stable = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      if (lk.out_data !== hold || !lk.out_valid) stable = 1'b0;
    end
    chk("t2 stall data stable", 32'(stable), 32'd1);
    chk("t2 stall ag_start", 32'(lk.ag_start), 32'd0);
    chk("t2 stall outstanding", 32'((issued_tb - i0) - (pops - p0)), 32'd4);
    @(posedge sys_clk);
    #1;
    lk.out_ready = 1'b1;
    wait_done("t2", d0, 1'b0);
    chk("t2 beats accepted", 32'(pops - p0), 32'd81);

    // Test 3: one out-of-range address
    seq_identity();
    seq[10] = 8'd85;
    d0 = done_cnt;
    p0 = pops;
    start_job();
    wait_done("t3", d0, 1'b1);
    chk("t3 beats accepted", 32'(pops - p0), 32'd81);

    // Test 5: reset mid-job, then a clean job
    d0 = done_cnt;
    p0 = pops;
    start_job();
    chk("t5 addr_err cleared by go", 32'(addr_err), 32'd0);
    wait_pops(p0, 40);
    @(posedge sys_clk);
    #1;
    reset = 1'b1;
    @(negedge sys_clk);
    exp_q.delete();
    chk("t5 reset out_valid", 32'(lk.out_valid), 32'd0);
    chk("t5 reset out_data", 32'(lk.out_data), 32'd0);
    chk("t5 reset ag_start", 32'(lk.ag_start), 32'd0);
    chk("t5 reset busy", 32'(busy), 32'd0);
    chk("t5 reset addr_err", 32'(addr_err), 32'd0);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    seq_identity();
    d0 = done_cnt;
    p0 = pops;
    start_job();
    wait_done("t5", d0, 1'b0);
    chk("t5 beats accepted", 32'(pops - p0), 32'd81);

    // Test 4: write/read collision on entry 5, then reread
    store_wr(8'd5, 16'h1234);
    store_wr(8'd133, 16'hDEAD);
    seq_identity();
    d0 = done_cnt;
    start_job();
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge sys_clk);
      if (lk.ag_start && !lk.ag_done && lk.ag_address == 8'd5) begin
        got = 1'b1;
        break;
      end
    end
    chk("t4 collision found", 32'(got), 32'd1);
    wr_en = 1'b1;
    wr_addr = 8'd5;
    wr_data = 16'hBEEF;
    @(posedge sys_clk);
    #1;
    wr_en = 1'b0;
    model[5] = 16'hBEEF;
    wait_done("t4", d0, 1'b0);
    d0 = done_cnt;
    start_job();
    wait_done("t4 reread", d0, 1'b0);

    // Test 6: go pulses during RUN and DRAIN are ignored
    seq_identity();
    d0 = done_cnt;
    start_job();
    repeat (10) @(posedge sys_clk);
    #1;
    go = 1'b1;
    @(posedge sys_clk);
    #1;
    go = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge sys_clk);
      if (lk.ag_done && busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6 reached drain", 32'(got), 32'd1);
    @(posedge sys_clk);
    #1;
    lk.out_ready = 1'b0;
    @(posedge sys_clk);
    #1;
    go = 1'b1;
    @(posedge sys_clk);
    #1;
    go = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    lk.out_ready = 1'b1;
    wait_done("t6", d0, 1'b0);
    stable = 1'b1;
    repeat (6) begin
      @(negedge sys_clk);
      if (busy || lk.ag_start || lk.out_valid) stable = 1'b0;
    end
    chk("t6 stays idle", 32'(stable), 32'd1);
    chk("t6 single done", 32'(done_cnt - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
